// File: rtl/alt_reg_pkg.sv
// Shared types and constants for the alternating-access register family.
// Grant codes name the single requester serviced in a given clock.
package alt_reg_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD1  = 2'd2,
    GNT_RD2  = 2'd3
  } grant_t;

  localparam logic PORT1 = 1'b0;
  localparam logic PORT2 = 1'b1;

  localparam int          DEFAULT_WIDTH     = 16;
  localparam logic [15:0] DEFAULT_RESET_VAL = 16'h0000;

  function automatic logic is_read(input grant_t g);
    return (g == GNT_RD1) || (g == GNT_RD2);
  endfunction

endpackage

// File: rtl/alt_read_reg16_if.sv
// Producer/consumer bus of the register: one write handshake and two read
// handshakes. The master side drives requests, the slave side responds.
interface alt_read_reg16_if #(
  parameter int WIDTH = 16
);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ack;
  logic             rd_req_1;
  logic             rd_valid_1;
  logic [WIDTH-1:0] rd_data_1;
  logic             rd_req_2;
  logic             rd_valid_2;
  logic [WIDTH-1:0] rd_data_2;
  logic             last_rd_port;

  modport master (
    output wr_en, wr_data, rd_req_1, rd_req_2,
    input  wr_ack, rd_valid_1, rd_data_1, rd_valid_2, rd_data_2, last_rd_port
  );

  modport slave (
    input  wr_en, wr_data, rd_req_1, rd_req_2,
    output wr_ack, rd_valid_1, rd_data_1, rd_valid_2, rd_data_2, last_rd_port
  );
endinterface

// File: rtl/alt_rr_arbiter.sv
// Two-requester arbiter with an alternating token. The token favours the
// requester it points to on contention and then moves to the other one.
module alt_rr_arbiter #(
  parameter bit FLIP_ALWAYS = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic accept,
  output logic gnt_a,
  output logic gnt_b
);

  // token_reg = 0 favours requester a, 1 favours requester b
  logic token_reg;
  logic token_next;

  always_comb begin
    gnt_a      = req_a && (!req_b || !token_reg);
    gnt_b      = req_b && (!req_a ||  token_reg);
    token_next = token_reg;
    // accept lets an outer arbiter veto the grant without moving the token
    if (accept && (gnt_a || gnt_b) && (FLIP_ALWAYS || (req_a && req_b))) begin
      token_next = gnt_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      token_reg <= 1'b0;
    end else begin
      token_reg <= token_next;
    end
  end

endmodule

// File: rtl/alt_read_reg16.sv
// Single-write, dual-read storage register servicing one access per clock,
// alternating between contending requesters so none of them starves.
module alt_read_reg16
  import alt_reg_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = DEFAULT_RESET_VAL
) (
  input  logic              clk,
  input  logic              rst,
  alt_read_reg16_if.slave   bus
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] rd_data_1_reg;
  logic [WIDTH-1:0] rd_data_2_reg;
  logic             wr_ack_reg;
  logic             rd_valid_1_reg;
  logic             rd_valid_2_reg;
  logic             last_rd_port_reg;

  logic   wr_elig;
  logic   rd1_elig;
  logic   rd2_elig;
  logic   side_gnt_wr;
  logic   side_gnt_rd;
  logic   rd_gnt_1;
  logic   rd_gnt_2;
  grant_t grant;

  // The response pulse masks its own requester so a held request is not served twice.
  assign wr_elig  = bus.wr_en    && !wr_ack_reg;
  assign rd1_elig = bus.rd_req_1 && !rd_valid_1_reg;
  assign rd2_elig = bus.rd_req_2 && !rd_valid_2_reg;

  alt_rr_arbiter #(.FLIP_ALWAYS(1'b0)) u_side_arb (
    .clk    (clk),
    .rst    (rst),
    .req_a  (wr_elig),
    .req_b  (rd1_elig || rd2_elig),
    .accept (1'b1),
    .gnt_a  (side_gnt_wr),
    .gnt_b  (side_gnt_rd)
  );

  // Read token only advances when the read side actually wins the cycle.
  alt_rr_arbiter #(.FLIP_ALWAYS(1'b1)) u_read_arb (
    .clk    (clk),
    .rst    (rst),
    .req_a  (rd1_elig),
    .req_b  (rd2_elig),
    .accept (side_gnt_rd),
    .gnt_a  (rd_gnt_1),
    .gnt_b  (rd_gnt_2)
  );

  always_comb begin
    grant = GNT_NONE;
    if (side_gnt_wr) begin
      grant = GNT_WR;
    end else if (side_gnt_rd) begin
      grant = rd_gnt_1 ? GNT_RD1 : (rd_gnt_2 ? GNT_RD2 : GNT_NONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q            <= RESET_VAL;
      rd_data_1_reg    <= '0;
      rd_data_2_reg    <= '0;
      wr_ack_reg       <= 1'b0;
      rd_valid_1_reg   <= 1'b0;
      rd_valid_2_reg   <= 1'b0;
      last_rd_port_reg <= PORT1;
    end else begin
      wr_ack_reg     <= (grant == GNT_WR);
      rd_valid_1_reg <= (grant == GNT_RD1);
      rd_valid_2_reg <= (grant == GNT_RD2);
      if (grant == GNT_WR) begin
        reg_q <= bus.wr_data;
      end
      if (grant == GNT_RD1) begin
        rd_data_1_reg <= reg_q;
      end
      if (grant == GNT_RD2) begin
        rd_data_2_reg <= reg_q;
      end
      if (is_read(grant)) begin
        last_rd_port_reg <= (grant == GNT_RD2) ? PORT2 : PORT1;
      end
    end
  end

  assign bus.wr_ack       = wr_ack_reg;
  assign bus.rd_valid_1   = rd_valid_1_reg;
  assign bus.rd_data_1    = rd_data_1_reg;
  assign bus.rd_valid_2   = rd_valid_2_reg;
  assign bus.rd_data_2    = rd_data_2_reg;
  assign bus.last_rd_port = last_rd_port_reg;

endmodule

// File: tb/tb_alt_read_reg16.sv
// Bench for alt_read_reg16: directed scenarios plus a randomized handshake
// run, all checked against a cycle-level model of the arbitration rules.
module tb_alt_read_reg16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  alt_read_reg16_if #(.WIDTH(16)) bus ();

  alt_read_reg16 #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: register contents, response pulses, and the two tokens
  logic [15:0] m_reg, m_d1, m_d2;
  bit          m_v1, m_v2, m_ack, m_last;
  bit          m_wr_turn;   // write side wins the next write/read conflict
  int          m_rd_turn;   // read port (1 or 2) that wins the next read conflict
  int          m_served;    // 0 none, 1 write, 2 read port 1, 3 read port 2

  task automatic model_edge();
    bit ew, e1, e2, rd_side;
    int g;
    if (rst) begin
      m_reg = 16'h0000; m_d1 = '0; m_d2 = '0;
      m_v1 = 0; m_v2 = 0; m_ack = 0; m_last = 0;
      m_wr_turn = 1; m_rd_turn = 1; m_served = 0;
      return;
    end
    ew = bus.wr_en && !m_ack;
    e1 = bus.rd_req_1 && !m_v1;
    e2 = bus.rd_req_2 && !m_v2;
    g = 0; rd_side = 0;
    if (ew && (e1 || e2)) begin
      if (m_wr_turn) g = 1; else rd_side = 1;
      m_wr_turn = !m_wr_turn;
    end else if (ew) begin
      g = 1;
    end else if (e1 || e2) begin
      rd_side = 1;
    end
    if (rd_side) begin
      if (e1 && e2) g = (m_rd_turn == 1) ? 2 : 3;
      else          g = e1 ? 2 : 3;
      m_rd_turn = (g == 2) ? 2 : 1;
    end
    if (g == 1) m_reg = bus.wr_data;
    if (g == 2) begin m_d1 = m_reg; m_last = 0; end
    if (g == 3) begin m_d2 = m_reg; m_last = 1; end
    m_ack = (g == 1); m_v1 = (g == 2); m_v2 = (g == 3);
    m_served = g;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 0; bus.wr_data = '0; bus.rd_req_1 = 0; bus.rd_req_2 = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.wr_en = 1; bus.rd_req_1 = 1; bus.rd_req_2 = 1; bus.wr_data = 16'hFFFF;
    rst = 1;
    tick(); tick();
    rst = 0;
    idle_inputs();
    checks++;
    if ({bus.wr_ack, bus.rd_valid_1, bus.rd_valid_2, bus.last_rd_port} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got ack/v1/v2/last=%b required 0000",
               {bus.wr_ack, bus.rd_valid_1, bus.rd_valid_2, bus.last_rd_port});
    end
    checks++;
    if (bus.rd_data_1 !== 16'h0000 || bus.rd_data_2 !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data: got d1=%h d2=%h required 0000 0000", bus.rd_data_1, bus.rd_data_2);
    end
    $display("reset: flags=%b d1=%h d2=%h",
             {bus.wr_ack, bus.rd_valid_1, bus.rd_valid_2, bus.last_rd_port}, bus.rd_data_1, bus.rd_data_2);
  endtask

  task automatic test_first_read();
    bus.rd_req_1 = 1;
    tick();
    bus.rd_req_1 = 0;
    checks++;
    if (bus.rd_valid_1 !== 1'b1 || bus.rd_data_1 !== 16'h0000 || bus.last_rd_port !== 1'b0) begin
      failures++;
      $display("FAIL first_read: got v1=%b d1=%h last=%b required 1 0000 0", bus.rd_valid_1, bus.rd_data_1, bus.last_rd_port);
    end
    tick();
    checks++;
    if (bus.rd_valid_1 !== 1'b0) begin
      failures++;
      $display("FAIL first_read_pulse: got v1=%b required 0", bus.rd_valid_1);
    end
    $display("first_read: d1=%h last=%b", bus.rd_data_1, bus.last_rd_port);
  endtask

  task automatic test_write_then_read();
    bus.wr_en = 1; bus.wr_data = 16'hA5A5;
    tick();
    bus.wr_en = 0;
    checks++;
    if (bus.wr_ack !== 1'b1) begin
      failures++;
      $display("FAIL write_ack: got %b required 1", bus.wr_ack);
    end
    bus.rd_req_2 = 1;
    tick();
    bus.rd_req_2 = 0;
    checks++;
    if (bus.rd_valid_2 !== 1'b1 || bus.rd_data_2 !== 16'hA5A5 || bus.last_rd_port !== 1'b1) begin
      failures++;
      $display("FAIL read2_after_write: got v2=%b d2=%h last=%b required 1 a5a5 1", bus.rd_valid_2, bus.rd_data_2, bus.last_rd_port);
    end
    checks++;
    if (bus.rd_data_1 !== 16'h0000 || bus.rd_valid_1 !== 1'b0) begin
      failures++;
      $display("FAIL read1_untouched: got v1=%b d1=%h required 0 0000", bus.rd_valid_1, bus.rd_data_1);
    end
    tick();
    $display("write_then_read: d2=%h d1=%h", bus.rd_data_2, bus.rd_data_1);
  endtask

  task automatic test_read_alternation();
    int exp_port[6] = '{1, 2, 1, 2, 1, 2};
    int got, prev;
    bus.wr_en = 1; bus.wr_data = 16'h1234;
    tick();
    bus.wr_en = 0;
    bus.rd_req_1 = 1; bus.rd_req_2 = 1;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      got = bus.rd_valid_1 ? (bus.rd_valid_2 ? 3 : 1) : (bus.rd_valid_2 ? 2 : 0);
      checks++;
      if (got !== exp_port[i] || got !== m_served - 1) begin
        failures++;
        $display("FAIL alternation[%0d]: got port %0d required %0d", i, got, exp_port[i]);
      end
      checks++;
      if (got == prev || (got == 1 ? bus.rd_data_1 : bus.rd_data_2) !== 16'h1234) begin
        failures++;
        $display("FAIL alternation_data[%0d]: got port %0d after %0d data d1=%h d2=%h required 1234", i, got, prev, bus.rd_data_1, bus.rd_data_2);
      end
      $display("alternation cycle %0d: port %0d", i, got);
      prev = got;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_conflict();
    rst = 1; tick(); rst = 0;
    bus.wr_en = 1; bus.wr_data = 16'hBEEF; bus.rd_req_1 = 1;
    tick();
    checks++;
    if (bus.wr_ack !== 1'b1 || bus.rd_valid_1 !== 1'b0) begin
      failures++;
      $display("FAIL conflict1_write_first: got ack=%b v1=%b required 1 0", bus.wr_ack, bus.rd_valid_1);
    end
    bus.wr_en = 0;
    tick();
    bus.rd_req_1 = 0;
    checks++;
    if (bus.rd_valid_1 !== 1'b1 || bus.rd_data_1 !== 16'hBEEF) begin
      failures++;
      $display("FAIL conflict1_read: got v1=%b d1=%h required 1 beef", bus.rd_valid_1, bus.rd_data_1);
    end
    tick();
    bus.wr_en = 1; bus.wr_data = 16'h0F0F; bus.rd_req_1 = 1;
    tick();
    checks++;
    if (bus.rd_valid_1 !== 1'b1 || bus.rd_data_1 !== 16'hBEEF || bus.wr_ack !== 1'b0) begin
      failures++;
      $display("FAIL conflict2_read_first: got v1=%b d1=%h ack=%b required 1 beef 0", bus.rd_valid_1, bus.rd_data_1, bus.wr_ack);
    end
    bus.rd_req_1 = 0;
    tick();
    bus.wr_en = 0;
    checks++;
    if (bus.wr_ack !== 1'b1) begin
      failures++;
      $display("FAIL conflict2_write: got ack=%b required 1", bus.wr_ack);
    end
    bus.rd_req_2 = 1;
    tick();
    bus.rd_req_2 = 0;
    checks++;
    if (bus.rd_data_2 !== 16'h0F0F || bus.rd_valid_2 !== 1'b1) begin
      failures++;
      $display("FAIL conflict2_readback: got v2=%b d2=%h required 1 0f0f", bus.rd_valid_2, bus.rd_data_2);
    end
    tick();
    $display("conflict: d1=%h d2=%h", bus.rd_data_1, bus.rd_data_2);
  endtask

  task automatic test_reset_mid();
    // Move both tokens away from their reset positions first
    bus.wr_en = 1; bus.wr_data = 16'h7777; bus.rd_req_1 = 1;
    tick();
    bus.wr_en = 0;
    tick();
    checks++;
    if (bus.rd_valid_1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_setup: got v1=%b required 1", bus.rd_valid_1);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({bus.rd_valid_1, bus.rd_valid_2, bus.wr_ack, bus.last_rd_port} !== 4'b0000 ||
        bus.rd_data_1 !== 16'h0000 || bus.rd_data_2 !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_outputs: got v1/v2/ack/last=%b d1=%h d2=%h required 0000 0000 0000",
               {bus.rd_valid_1, bus.rd_valid_2, bus.wr_ack, bus.last_rd_port}, bus.rd_data_1, bus.rd_data_2);
    end
    bus.wr_en = 1; bus.wr_data = 16'h5555; bus.rd_req_1 = 1; bus.rd_req_2 = 1;
    tick();
    bus.wr_en = 0;
    checks++;
    if (bus.wr_ack !== 1'b1 || bus.rd_valid_1 !== 1'b0 || bus.rd_valid_2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_conflict_token: got ack=%b v1=%b v2=%b required 1 0 0", bus.wr_ack, bus.rd_valid_1, bus.rd_valid_2);
    end
    tick();
    checks++;
    if (bus.rd_valid_1 !== 1'b1 || bus.rd_valid_2 !== 1'b0 || bus.rd_data_1 !== 16'h5555) begin
      failures++;
      $display("FAIL reset_mid_read_token: got v1=%b v2=%b d1=%h required 1 0 5555", bus.rd_valid_1, bus.rd_valid_2, bus.rd_data_1);
    end
    idle_inputs();
    tick(); tick();
    $display("reset_mid: d1=%h last=%b", bus.rd_data_1, bus.last_rd_port);
  endtask

  task automatic test_random();
    int served_wr = 0, served_rd = 0;
    for (int i = 0; i < 400; i++) begin
      // Requesters drop or renew after a response, start fresh at random otherwise
      if (bus.wr_en && bus.wr_ack) bus.wr_en = ($urandom_range(0, 1) == 1);
      else if (!bus.wr_en)          bus.wr_en = ($urandom_range(0, 2) == 0);
      if (bus.wr_en && (bus.wr_ack || !m_ack && $urandom_range(0, 7) == 0 && 0)) bus.wr_data = 16'($urandom);
      if (bus.rd_req_1 && bus.rd_valid_1) bus.rd_req_1 = ($urandom_range(0, 1) == 1);
      else if (!bus.rd_req_1)              bus.rd_req_1 = ($urandom_range(0, 1) == 0);
      if (bus.rd_req_2 && bus.rd_valid_2) bus.rd_req_2 = ($urandom_range(0, 1) == 1);
      else if (!bus.rd_req_2)              bus.rd_req_2 = ($urandom_range(0, 1) == 0);
      if (!bus.wr_en) bus.wr_data = 16'($urandom);
      tick();
      served_wr += m_ack; served_rd += m_v1 + m_v2;
      checks++;
      if ({bus.wr_ack, bus.rd_valid_1, bus.rd_valid_2, bus.last_rd_port} !== {m_ack, m_v1, m_v2, m_last} ||
          bus.rd_data_1 !== m_d1 || bus.rd_data_2 !== m_d2) begin
        failures++;
        $display("FAIL random[%0d]: got ack/v1/v2/last=%b d1=%h d2=%h required %b %h %h", i,
                 {bus.wr_ack, bus.rd_valid_1, bus.rd_valid_2, bus.last_rd_port}, bus.rd_data_1, bus.rd_data_2,
                 {m_ack, m_v1, m_v2, m_last}, m_d1, m_d2);
      end
    end
    $display("random: 400 cycles, writes=%0d reads=%0d", served_wr, served_rd);
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_first_read();
    test_write_then_read();
    test_read_alternation();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
